// File: rtl/alu_operand_stage.sv
// ALU operand stage: selects op1/op2 from register, immediate and PC
// sources, forwards results from younger pipeline stages, stalls while a
// selected forwarded result is still pending, and registers the operands
// into the ID/EX boundary.
//
// Handshake: a transfer happens on an edge where valid and ready are both 1.
// out_valid/op1/op2 stay stable while out_valid=1 and out_ready=0. in_ready
// is combinational and does not depend on in_valid. flush and rst override
// both sides.
module alu_operand_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              alu_src,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [XLEN-1:0]         imm32,
  input  logic [XLEN-1:0]         pc,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*5-1:0]    fwd_rd,
  input  logic [NUM_FWD-1:0]      fwd_pend,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         op1,
  output logic [XLEN-1:0]         op2,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int SHW = $clog2(XLEN);

  logic            out_valid_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [XLEN-1:0] op1_d, op2_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic            rs1_hit, rs2_hit;
  logic            rs1_pend, rs2_pend;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            use_rs1, use_rs2;
  logic            hazard;
  logic            accept;
  logic            stall_inc;

  // rs1 source: youngest (lowest index) matching forward source wins; x0 never forwards
  always_comb begin
    rs1_hit  = 1'b0;
    rs1_pend = 1'b0;
    rs1_val  = rs1_data;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!rs1_hit && fwd_valid[i] && (fwd_rd[5*i +: 5] == rs1_addr) && (rs1_addr != 5'd0)) begin
        rs1_hit  = 1'b1;
        rs1_pend = fwd_pend[i];
        rs1_val  = fwd_data[XLEN*i +: XLEN];
      end
    end
  end

  // rs2 source: same priority rule as rs1
  always_comb begin
    rs2_hit  = 1'b0;
    rs2_pend = 1'b0;
    rs2_val  = rs2_data;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!rs2_hit && fwd_valid[i] && (fwd_rd[5*i +: 5] == rs2_addr) && (rs2_addr != 5'd0)) begin
        rs2_hit  = 1'b1;
        rs2_pend = fwd_pend[i];
        rs2_val  = fwd_data[XLEN*i +: XLEN];
      end
    end
  end

  // Operand mux per mode; use_rsN marks which register reads can cause hazards
  always_comb begin
    op1_d   = '0;
    op2_d   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (alu_src)
      3'd0: begin op1_d = rs1_val; op2_d = rs2_val; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      3'd1: begin op1_d = rs1_val; op2_d = imm32;   use_rs1 = 1'b1; end
      3'd2: begin op1_d = pc;      op2_d = XLEN'(4); end
      3'd3: begin op1_d = '0;      op2_d = imm32; end
      3'd4: begin op1_d = pc;      op2_d = imm32; end
      3'd5: begin
        op1_d   = rs1_val;
        op2_d   = {{(XLEN-SHW){1'b0}}, imm32[SHW-1:0]};
        use_rs1 = 1'b1;
      end
      3'd6: begin op1_d = pc;      op2_d = rs2_val; use_rs2 = 1'b1; end
      default: begin op1_d = '0;   op2_d = '0; end
    endcase
  end

  assign hazard    = (use_rs1 && rs1_pend) || (use_rs2 && rs2_pend);
  assign in_ready  = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept    = in_valid && in_ready;
  assign stall_inc = in_valid && hazard && !flush;

  // Output register: flush beats accept/hold; drain clears valid but keeps data
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Stall counter: counts hazard cycles with a waiting instruction, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed scenarios plus a random
// back-to-back run, with a scoreboard queue of expected {op1, op2} pairs.
module tb_alu_operand_stage;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              alu_src;
  logic [4:0]              rs1_addr, rs2_addr;
  logic [XLEN-1:0]         rs1_data, rs2_data, imm32, pc;
  logic [NUM_FWD-1:0]      fwd_valid, fwd_pend;
  logic [NUM_FWD*5-1:0]    fwd_rd;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         op1, op2;
  logic [CNT_W-1:0]        stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [2*XLEN-1:0] exp_q[$];
  logic [2*XLEN-1:0] exp_v;

  alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_src(alu_src), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm32(imm32), .pc(pc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_pend(fwd_pend), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .stall_cnt(stall_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: every consumed output must match the oldest expected pair
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got op1=%h op2=%h, required no output", op1, op2);
      end else begin
        exp_v = exp_q.pop_front();
        if ({op1, op2} !== exp_v) begin
          errors++;
          $display("FAIL out_data: got op1=%h op2=%h, required op1=%h op2=%h",
                   op1, op2, exp_v[2*XLEN-1:XLEN], exp_v[XLEN-1:0]);
        end
      end
    end
  end

  // Reference: forwarded value of a register read
  function automatic logic [XLEN-1:0] fwd_pick(input logic [4:0] a, input logic [XLEN-1:0] regv);
    logic [XLEN-1:0] v;
    logic found;
    v = regv;
    found = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!found && a != 5'd0 && fwd_valid[i] && fwd_rd[5*i +: 5] == a) begin
        found = 1'b1;
        v = fwd_data[XLEN*i +: XLEN];
      end
    end
    return v;
  endfunction

  // Reference: expected {op1, op2} for the current inputs
  function automatic logic [2*XLEN-1:0] model_ops();
    logic [XLEN-1:0] r1, r2;
    r1 = fwd_pick(rs1_addr, rs1_data);
    r2 = fwd_pick(rs2_addr, rs2_data);
    case (alu_src)
      3'd0: return {r1, r2};
      3'd1: return {r1, imm32};
      3'd2: return {pc, 32'd4};
      3'd3: return {32'd0, imm32};
      3'd4: return {pc, imm32};
      3'd5: return {r1, imm32 & 32'h1F};
      3'd6: return {pc, r2};
      default: return {32'd0, 32'd0};
    endcase
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    in_valid = 1'b0; alu_src = 3'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    rs1_data = '0; rs2_data = '0; imm32 = '0; pc = '0;
    fwd_valid = '0; fwd_pend = '0; fwd_rd = '0; fwd_data = '0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic set_fwd(input int i, input logic v, input logic [4:0] rd,
                         input logic p, input logic [XLEN-1:0] d);
    fwd_valid[i] = v;
    fwd_rd[5*i +: 5] = rd;
    fwd_pend[i] = p;
    fwd_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic put_insn(input logic [2:0] m, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                          input logic [XLEN-1:0] im, input logic [XLEN-1:0] p);
    alu_src = m; rs1_addr = a1; rs2_addr = a2; rs1_data = d1; rs2_data = d2;
    imm32 = im; pc = p; in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (op1 !== '0) begin errors++; $display("FAIL reset_op1: got %h, required 0", op1); end
    checks++; if (op2 !== '0) begin errors++; $display("FAIL reset_op2: got %h, required 0", op2); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt: got %0d, required 0", stall_cnt); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_basic();
    tick();
    put_insn(3'd0, 5'd3, 5'd4, 32'h10, 32'h20, 32'h0, 32'h0);
    exp_q.push_back({32'h10, 32'h20});
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b, required 1", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid: got %b, required 0", out_valid); end
    checks++; if (op1 !== 32'h10) begin errors++; $display("FAIL drain_op1_hold: got %h, required 10", op1); end
  endtask

  task automatic test_fwd_priority();
    tick();
    set_fwd(0, 1'b1, 5'd5, 1'b0, 32'hAA);
    set_fwd(1, 1'b1, 5'd5, 1'b0, 32'hBB);
    put_insn(3'd0, 5'd5, 5'd9, 32'h1, 32'h99, 32'h0, 32'h0);
    exp_q.push_back({32'hAA, 32'h99});
    tick();
    // x0 never forwards and never stalls, even against a pending match
    set_fwd(0, 1'b1, 5'd0, 1'b1, 32'hDEAD);
    set_fwd(1, 1'b0, 5'd0, 1'b0, 32'h0);
    put_insn(3'd1, 5'd0, 5'd0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h0);
    exp_q.push_back({32'h1234, 32'hFFFF_FFFF});
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_no_hazard: got in_ready=%b, required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    fwd_valid = '0; fwd_pend = '0;
    repeat (2) tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    // younger pending match must stall even though an older ready match exists
    set_fwd(0, 1'b1, 5'd7, 1'b1, 32'h0);
    set_fwd(1, 1'b1, 5'd7, 1'b0, 32'h77);
    put_insn(3'd1, 5'd7, 5'd0, 32'h3, 32'h0, 32'h64, 32'h0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_cycle1: got in_ready=%b, required 0", in_ready); end
    tick();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_cycle2: got in_ready=%b, required 0", in_ready); end
    tick();
    set_fwd(0, 1'b1, 5'd7, 1'b0, 32'h55);
    exp_q.push_back({32'h55, 32'h64});
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got in_ready=%b, required 1", in_ready); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt_2: got %0d, required 2", stall_cnt); end
    tick();
    in_valid = 1'b0;
    fwd_valid = '0; fwd_pend = '0;
    repeat (2) tick();
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt_idle: got %0d, required 2", stall_cnt); end
  endtask

  task automatic test_unused_operand();
    set_fwd(0, 1'b1, 5'd7, 1'b1, 32'h0);
    put_insn(3'd3, 5'd7, 5'd7, 32'h3, 32'h4, 32'h0000_0ABC, 32'h0);
    exp_q.push_back({32'h0, 32'h0000_0ABC});
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unused_no_hazard: got in_ready=%b, required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    fwd_valid = '0; fwd_pend = '0;
    repeat (2) tick();
  endtask

  task automatic test_hold_flush();
    put_insn(3'd4, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 32'h200);
    exp_q.push_back({32'h200, 32'h8});
    tick();
    out_ready = 1'b0;
    put_insn(3'd7, 5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 32'h4);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b, required 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b, required 0", in_ready); end
    tick();
    flush = 1'b1;
    @(negedge clk);
    checks++; if ({op1, op2} !== {32'h200, 32'h8}) begin errors++; $display("FAIL hold_stable: got %h/%h, required 200/8", op1, op2); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_capture: got %b, required 0", out_valid); end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    put_insn(3'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h300);
    exp_q.push_back({32'h300, 32'h4});
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midhold_valid: got %b, required 1", out_valid); end
    tick();
    rst = 1'b1;
    void'(exp_q.pop_back());
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, op1, op2} !== {1'b0, 64'h0}) begin errors++; $display("FAIL midhold_reset: got v=%b %h/%h, required v=0 0/0", out_valid, op1, op2); end
    tick();
  endtask

  task automatic test_shift_pc();
    put_insn(3'd5, 5'd2, 5'd0, 32'hCAFE, 32'h0, 32'h0000_0425, 32'h0);
    exp_q.push_back({32'hCAFE, 32'h5});
    tick();
    put_insn(3'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h100);
    exp_q.push_back({32'h100, 32'h4});
    tick();
    put_insn(3'd6, 5'd0, 5'd6, 32'h0, 32'h66, 32'h0, 32'h180);
    exp_q.push_back({32'h180, 32'h66});
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      alu_src  = 3'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 3));
      rs2_addr = 5'($urandom_range(0, 3));
      rs1_data = $urandom; rs2_data = $urandom; imm32 = $urandom; pc = $urandom;
      for (int i = 0; i < NUM_FWD; i++)
        set_fwd(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'b0, $urandom);
      in_valid = 1'b1;
      exp_q.push_back(model_ops());
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b, required 1", n, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    fwd_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_stall_sat();
    apply_reset();
    set_fwd(0, 1'b1, 5'd9, 1'b1, 32'h0);
    put_insn(3'd0, 5'd1, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    repeat (3) tick();
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL flush_no_count: got %0d, required 0", stall_cnt); end
    flush = 1'b0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL stall_cnt_fffe: got %h, required fffe", stall_cnt); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_cnt_sat: got %h, required ffff", stall_cnt); end
    #1;
    in_valid = 1'b0;
    fwd_valid = '0; fwd_pend = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fwd_priority();
    test_load_use();
    test_unused_operand();
    test_hold_flush();
    test_reset_mid_hold();
    test_shift_pc();
    test_back_to_back();
    test_stall_sat();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
